// File: rtl/disp7seg_scan_pkg.sv
// disp_pkg: FSM state type, digit codes, segment patterns and helpers for disp7seg_scan.
// Hex glyphs A-F exist only when DISP_HEX_EN is defined.
package disp_pkg;

   typedef enum logic [1:0] {IDLE, CONV, FORMAT} disp_state_t;

   typedef logic [4:0] digit_code_t;

   localparam digit_code_t CODE_ZERO  = 5'd0;
   localparam digit_code_t CODE_MINUS = 5'd16;
   localparam digit_code_t CODE_BLANK = 5'd17;

   // Active-low, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
`ifdef DISP_HEX_EN
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
`endif

   // Decimal digits needed for a w-bit unsigned value (1233/4096 ~ log10(2)).
   function automatic int unsigned bcd_digits(int unsigned w);
      return ((w * 1233) >> 12) + 1;
   endfunction

   function automatic logic [6:0] code_to_seg(digit_code_t c);
      case (c)
         5'd0:       return SEG_0;
         5'd1:       return SEG_1;
         5'd2:       return SEG_2;
         5'd3:       return SEG_3;
         5'd4:       return SEG_4;
         5'd5:       return SEG_5;
         5'd6:       return SEG_6;
         5'd7:       return SEG_7;
         5'd8:       return SEG_8;
         5'd9:       return SEG_9;
`ifdef DISP_HEX_EN
         5'd10:      return SEG_A;
         5'd11:      return SEG_B;
         5'd12:      return SEG_C;
         5'd13:      return SEG_D;
         5'd14:      return SEG_E;
         5'd15:      return SEG_F;
`endif
         CODE_MINUS: return SEG_MINUS;
         default:    return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/disp7seg_scan_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one add-3/shift iteration per clock.
// start loads bin; done pulses one cycle after the DATA_W-th iteration.
module bin2bcd_seq
   import disp_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int BCD_DIGITS = int'(bcd_digits(16))
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [DATA_W-1:0]       bin,
   output logic                    done,
   output logic [4*BCD_DIGITS-1:0] bcd
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   logic [DATA_W-1:0]       shreg;
   logic [CNT_W-1:0]        cnt;
   logic                    running;
   logic [4*BCD_DIGITS-1:0] adj;

   always_comb begin
      adj = bcd;
      for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
         if (bcd[4*d +: 4] >= 4'd5)
            adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shreg   <= '0;
         bcd     <= '0;
         cnt     <= '0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            shreg   <= bin;
            bcd     <= '0;
            cnt     <= '0;
            running <= 1'b1;
         end else if (running) begin
            bcd   <= {adj[4*BCD_DIGITS-2:0], shreg[DATA_W-1]};
            shreg <= shreg << 1;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) begin
               running <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/disp7seg_scan.sv
// disp7seg_scan: signed value -> sign+BCD -> multiplexed 7-segment scan.
// Define DISP_HEX_EN to show the raw value as hex digits instead (no conversion).
module disp7seg_scan
   import disp_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int N_DIGITS = 8
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                scan_tick,
   input  logic                load,
   input  logic [DATA_W-1:0]   value,
   output logic                busy,
   output logic [N_DIGITS-1:0] an,
   output logic [6:0]          seg,
   output logic                dp
);

   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   disp_state_t      state;
   digit_code_t      codes   [N_DIGITS];
   digit_code_t      codes_d [N_DIGITS];
   digit_code_t      fmt     [N_DIGITS];
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_d;

`ifdef DISP_HEX_EN
   localparam int HEX_DIGITS = (DATA_W + 3) / 4;

   logic [DATA_W-1:0] val_r;

   always_comb begin
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
         fmt[i] = CODE_BLANK;
         if (i < HEX_DIGITS)
            fmt[i] = {1'b0, 4'(val_r >> (4 * i))};
      end
   end
`else
   localparam int BCD_DIGITS = int'(bcd_digits(DATA_W));

   logic                    neg;
   logic                    conv_done;
   logic [DATA_W-1:0]       mag;
   logic [4*BCD_DIGITS-1:0] bcd;
   logic [4*N_DIGITS-1:0]   bcd_pad;

   // Upper bit of the DATA_W+1 magnitude is always 0, so the unsigned
   // DATA_W-bit negate already holds -2^(DATA_W-1) exactly.
   assign mag     = value[DATA_W-1] ? (~value + DATA_W'(1)) : value;
   assign bcd_pad = (4*N_DIGITS)'(bcd);

   bin2bcd_seq #(
      .DATA_W     (DATA_W),
      .BCD_DIGITS (BCD_DIGITS)
   ) u_bin2bcd (
      .clk   (clk),
      .reset (reset),
      .start (state == IDLE && load),
      .bin   (mag),
      .done  (conv_done),
      .bcd   (bcd)
   );

   always_comb begin
      int unsigned msd;
      msd = 0;
      for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
         if (bcd[4*d +: 4] != 4'd0)
            msd = d;
      end
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
         fmt[i] = CODE_BLANK;
         if (i <= msd)
            fmt[i] = {1'b0, bcd_pad[4*i +: 4]};
         else if (neg && i == msd + 1)
            fmt[i] = CODE_MINUS;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
`ifdef DISP_HEX_EN
         val_r <= '0;
`else
         neg   <= 1'b0;
`endif
         for (int unsigned i = 0; i < N_DIGITS; i++)
            codes[i] <= (i == 0) ? CODE_ZERO : CODE_BLANK;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
`ifdef DISP_HEX_EN
                  val_r <= value;
                  busy  <= 1'b1;
                  state <= FORMAT;
`else
                  neg   <= value[DATA_W-1];
                  state <= CONV;
`endif
               end
            end
            CONV: begin
               busy <= 1'b1;
`ifndef DISP_HEX_EN
               if (conv_done)
                  state <= FORMAT;
`endif
            end
            FORMAT: begin
               for (int unsigned i = 0; i < N_DIGITS; i++)
                  codes[i] <= fmt[i];
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // seg looks at the frame being written this edge so a new frame appears at once.
   always_comb begin
      for (int unsigned i = 0; i < N_DIGITS; i++)
         codes_d[i] = (state == FORMAT) ? fmt[i] : codes[i];
   end

   assign idx_d = !scan_tick ? idx :
                  (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         idx <= '0;
         an  <= ~N_DIGITS'(1);
         seg <= SEG_0;
      end else begin
         idx <= idx_d;
         an  <= ~(N_DIGITS'(1) << idx_d);
         seg <= code_to_seg(codes_d[idx_d]);
      end
   end

   assign dp = 1'b1;

endmodule
